// File: rtl/fetch_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buffer
// Description : Two-entry fetch-to-decode skid buffer with flush. ready_o and
//               valid_o come from state flops only. Optional stall counter is
//               enabled by defining FETCH_SKID_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buffer #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               valid_i,
    input  logic [INSTR_W-1:0] instruction_i,
    input  logic [PC_W-1:0]    pc_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instruction_o,
    output logic [PC_W-1:0]    pc_o,
    input  logic               ready_i
`ifdef FETCH_SKID_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load_main;
    logic               w_main_from_skid;
    logic               w_load_skid;

    logic [INSTR_W-1:0] r_main_instr;
    logic [PC_W-1:0]    r_main_pc;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [PC_W-1:0]    r_skid_pc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Flush overrides everything; an input offered alongside it is dropped.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush_i) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (valid_i) begin
                        w_load_main = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (valid_i && ready_i) begin
                        w_load_main = 1'b1;
                    end else if (valid_i) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = ST_FULL;
                    end else if (ready_i) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (ready_i) begin
                        w_main_from_skid = 1'b1;
                        w_state_nxt      = ST_BUSY;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_main_instr <= '0;
            r_main_pc    <= '0;
        end else if (w_load_main) begin
            r_main_instr <= instruction_i;
            r_main_pc    <= pc_i;
        end else if (w_main_from_skid) begin
            r_main_instr <= r_skid_instr;
            r_main_pc    <= r_skid_pc;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else if (w_load_skid) begin
            r_skid_instr <= instruction_i;
            r_skid_pc    <= pc_i;
        end
    end

    assign valid_o       = (r_state != ST_EMPTY);
    assign ready_o       = (r_state != ST_FULL);
    assign instruction_o = r_main_instr;
    assign pc_o          = r_main_pc;

`ifdef FETCH_SKID_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (flush_i) begin
            r_stall_cnt <= '0;
        end else if (valid_o && !ready_i) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire
